// File: rtl/remove_cp_if.sv
// Sample-stream bus for the cyclic-prefix remover: serial input samples in,
// forwarded body samples plus per-symbol status out.
interface remove_cp_if;
   logic signed [15:0] DAT_I_r;
   logic signed [15:0] DAT_I_i;
   logic               STB_I;
   logic               SOF_I;
   logic signed [15:0] DAT_O_r;
   logic signed [15:0] DAT_O_i;
   logic               STB_O;
   logic               SOS_O;
   logic               EOS_O;
   logic [23:0]        METRIC_O;
   logic               METRIC_VLD;
   logic               SYNC_ERR;
   logic [15:0]        SYM_CNT_O;

   modport slave (
      input  DAT_I_r, DAT_I_i, STB_I, SOF_I,
      output DAT_O_r, DAT_O_i, STB_O, SOS_O, EOS_O,
      output METRIC_O, METRIC_VLD, SYNC_ERR, SYM_CNT_O
   );

   modport master (
      output DAT_I_r, DAT_I_i, STB_I, SOF_I,
      input  DAT_O_r, DAT_O_i, STB_O, SOS_O, EOS_O,
      input  METRIC_O, METRIC_VLD, SYNC_ERR, SYM_CNT_O
   );
endinterface

// File: rtl/remove_cp.sv
// Strips the cyclic prefix from an OFDM sample stream, forwards the body and
// scores prefix/tail agreement as a sum of absolute differences per symbol.
module remove_cp #(
   parameter int LCP  = 16,
   parameter int NFFT = 48
) (
   input  logic        CLK_I,
   input  logic        RST_I,
   remove_cp_if.slave  bus
);
   localparam int IW   = $clog2(NFFT + 1);
   localparam int CW   = (LCP > 1) ? $clog2(LCP) : 1;
   localparam int TAIL = NFFT - LCP;

   typedef enum logic [1:0] {IDLE, CP, BODY} state_t;

   state_t             state_q, state_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic [23:0]        acc_q, acc_d;
   logic signed [15:0] dat_r_q, dat_r_d, dat_i_q, dat_i_d;
   logic               stb_q, stb_d, sos_q, sos_d, eos_q, eos_d;
   logic [23:0]        metric_q, metric_d;
   logic               mvld_q, mvld_d, serr_q, serr_d;
   logic [15:0]        cnt_q, cnt_d;

   logic signed [15:0] cp_r_q [LCP];
   logic signed [15:0] cp_i_q [LCP];
   logic               cp_we;
   logic [CW-1:0]      cp_wa;
   logic [CW-1:0]      cp_ra;

   logic [16:0]        d_r, d_i, a_r, a_i;
   logic [23:0]        term;
   logic               in_tail;

   // Tail sample k pairs with prefix sample k-(NFFT-LCP); the sum below is only
   // meaningful while in_tail holds.
   assign cp_ra   = CW'(idx_q - IW'(TAIL));
   assign in_tail = (idx_q >= IW'(TAIL));
   assign d_r     = {bus.DAT_I_r[15], bus.DAT_I_r} - {cp_r_q[cp_ra][15], cp_r_q[cp_ra]};
   assign d_i     = {bus.DAT_I_i[15], bus.DAT_I_i} - {cp_i_q[cp_ra][15], cp_i_q[cp_ra]};
   assign a_r     = d_r[16] ? (~d_r + 17'd1) : d_r;
   assign a_i     = d_i[16] ? (~d_i + 17'd1) : d_i;
   assign term    = 24'(a_r) + 24'(a_i);

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      acc_d    = acc_q;
      dat_r_d  = dat_r_q;
      dat_i_d  = dat_i_q;
      stb_d    = 1'b0;
      sos_d    = 1'b0;
      eos_d    = 1'b0;
      metric_d = metric_q;
      mvld_d   = 1'b0;
      serr_d   = 1'b0;
      cnt_d    = cnt_q;
      cp_we    = 1'b0;
      cp_wa    = '0;
      if (bus.STB_I) begin
         if (bus.SOF_I) begin
            // A start-of-frame always opens a new symbol; mid-symbol it also aborts.
            serr_d = (state_q != IDLE);
            acc_d  = '0;
            cp_we  = 1'b1;
            if (LCP == 1) begin
               state_d = BODY;
               idx_d   = '0;
            end else begin
               state_d = CP;
               idx_d   = IW'(1);
            end
         end else begin
            case (state_q)
               CP: begin
                  cp_we = 1'b1;
                  cp_wa = CW'(idx_q);
                  if (idx_q == IW'(LCP - 1)) begin
                     state_d = BODY;
                     idx_d   = '0;
                  end else begin
                     idx_d = idx_q + IW'(1);
                  end
               end
               BODY: begin
                  stb_d   = 1'b1;
                  dat_r_d = bus.DAT_I_r;
                  dat_i_d = bus.DAT_I_i;
                  sos_d   = (idx_q == '0);
                  if (in_tail) acc_d = acc_q + term;
                  if (idx_q == IW'(NFFT - 1)) begin
                     eos_d    = 1'b1;
                     mvld_d   = 1'b1;
                     metric_d = acc_q + term;
                     cnt_d    = cnt_q + 16'd1;
                     state_d  = IDLE;
                     idx_d    = '0;
                  end else begin
                     idx_d = idx_q + IW'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         acc_q    <= '0;
         dat_r_q  <= '0;
         dat_i_q  <= '0;
         stb_q    <= 1'b0;
         sos_q    <= 1'b0;
         eos_q    <= 1'b0;
         metric_q <= '0;
         mvld_q   <= 1'b0;
         serr_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         acc_q    <= acc_d;
         dat_r_q  <= dat_r_d;
         dat_i_q  <= dat_i_d;
         stb_q    <= stb_d;
         sos_q    <= sos_d;
         eos_q    <= eos_d;
         metric_q <= metric_d;
         mvld_q   <= mvld_d;
         serr_q   <= serr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         for (int n = 0; n < LCP; n++) begin
            cp_r_q[n] <= '0;
            cp_i_q[n] <= '0;
         end
      end else if (cp_we) begin
         cp_r_q[cp_wa] <= bus.DAT_I_r;
         cp_i_q[cp_wa] <= bus.DAT_I_i;
      end
   end

   assign bus.DAT_O_r    = dat_r_q;
   assign bus.DAT_O_i    = dat_i_q;
   assign bus.STB_O      = stb_q;
   assign bus.SOS_O      = sos_q;
   assign bus.EOS_O      = eos_q;
   assign bus.METRIC_O   = metric_q;
   assign bus.METRIC_VLD = mvld_q;
   assign bus.SYNC_ERR   = serr_q;
   assign bus.SYM_CNT_O  = cnt_q;
endmodule
